// File: rtl/trojan_response_checker_if.sv
// Stimulus/response bundle between the test source and the golden-model checker.
// The master drives the applied vector and run control; the slave reports status.
interface trojan_response_checker_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             in_valid;
  logic [2:0]       in_abc;
  logic [3:0]       in_resp;
  logic [1:0]       state;
  logic [3:0]       mismatch_vec;
  logic [3:0]       fail_mask;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             alarm;
  logic [2:0]       first_fail_abc;
  logic             first_fail_vld;

  modport master (
    output start, stop, in_valid, in_abc, in_resp,
    input  state, mismatch_vec, fail_mask, vec_cnt, err_cnt, alarm,
           first_fail_abc, first_fail_vld
  );

  modport slave (
    input  start, stop, in_valid, in_abc, in_resp,
    output state, mismatch_vec, fail_mask, vec_cnt, err_cnt, alarm,
           first_fail_abc, first_fail_vld
  );
endinterface

// File: rtl/trojan_response_checker.sv
// Golden-model checker for the 3-in/4-out circuit under test: two-stage compare,
// saturating vector/error counters, first-fail capture and a sticky alarm.
module trojan_response_checker #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned ALARM_THRESH = 4,
  parameter int unsigned NUM_VECTORS  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  trojan_response_checker_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALARM = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             s1_vld;
  logic [2:0]       s1_abc;
  logic [3:0]       s1_resp;
  logic [3:0]       mismatch_q;
  logic [3:0]       fail_mask_q;
  logic [CNT_W-1:0] vec_q;
  logic [CNT_W-1:0] err_q;
  logic             alarm_q;
  logic [2:0]       ff_abc_q;
  logic             ff_vld_q;

  logic [3:0]       golden;
  logic [3:0]       mismatch;
  logic             vec_inc;
  logic             err_inc;
  logic [CNT_W-1:0] vec_next;
  logic [CNT_W-1:0] err_next;
  logic             thresh_hit;
  logic             num_hit;
  logic             capture;

  // Stage-2 arithmetic, shared by the datapath and the FSM so both see the same edge
  always_comb begin
    golden     = {s1_abc[2] & s1_abc[1],
                  s1_abc[2] | s1_abc[0],
                  ~s1_abc[0],
                  s1_abc[2] & s1_abc[1] & s1_abc[0]};
    mismatch   = s1_resp ^ golden;
    vec_inc    = s1_vld && (vec_q != CNT_MAX);
    err_inc    = s1_vld && (mismatch != 4'd0) && (err_q != CNT_MAX);
    vec_next   = vec_q + CNT_W'(vec_inc);
    err_next   = err_q + CNT_W'(err_inc);
    thresh_hit = s1_vld && (32'(err_next) >= ALARM_THRESH);
    num_hit    = (NUM_VECTORS != 0) && s1_vld && (32'(vec_next) >= NUM_VECTORS);
    capture    = bus.in_valid && ((state_q == RUN) || (state_q == ALARM));
  end

  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN, ALARM: begin
          if (bus.stop || num_hit)
            state_d = DONE;
          else if ((state_q == RUN) && thresh_hit)
            state_d = ALARM;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld      <= 1'b0;
      s1_abc      <= '0;
      s1_resp     <= '0;
      mismatch_q  <= '0;
      fail_mask_q <= '0;
      vec_q       <= '0;
      err_q       <= '0;
      alarm_q     <= 1'b0;
      ff_abc_q    <= '0;
      ff_vld_q    <= 1'b0;
    end else if (bus.start) begin
      s1_vld      <= 1'b0;
      mismatch_q  <= '0;
      fail_mask_q <= '0;
      vec_q       <= '0;
      err_q       <= '0;
      alarm_q     <= 1'b0;
      ff_abc_q    <= '0;
      ff_vld_q    <= 1'b0;
    end else begin
      s1_vld <= capture;
      if (capture) begin
        s1_abc  <= bus.in_abc;
        s1_resp <= bus.in_resp;
      end
      // A vector captured on the edge that leaves RUN/ALARM still drains here in DONE
      if (s1_vld) begin
        mismatch_q  <= mismatch;
        fail_mask_q <= fail_mask_q | mismatch;
        vec_q       <= vec_next;
        err_q       <= err_next;
        if (thresh_hit)
          alarm_q <= 1'b1;
        if ((mismatch != 4'd0) && !ff_vld_q) begin
          ff_abc_q <= s1_abc;
          ff_vld_q <= 1'b1;
        end
      end
    end
  end

  assign bus.state          = state_q;
  assign bus.mismatch_vec   = mismatch_q;
  assign bus.fail_mask      = fail_mask_q;
  assign bus.vec_cnt        = vec_q;
  assign bus.err_cnt        = err_q;
  assign bus.alarm          = alarm_q;
  assign bus.first_fail_abc = ff_abc_q;
  assign bus.first_fail_vld = ff_vld_q;

endmodule

// File: tb/tb_trojan_response_checker.sv
// Directed bench: dut_a (16-bit counters, 8-vector runs) feeds a scoreboard monitor;
// dut_b (3-bit counters, unlimited) exercises counter saturation.
module tb_trojan_response_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trojan_response_checker_if #(.CNT_W(16)) ifa ();
  trojan_response_checker_if #(.CNT_W(3))  ifb ();

  trojan_response_checker #(.CNT_W(16), .ALARM_THRESH(4), .NUM_VECTORS(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  trojan_response_checker #(.CNT_W(3), .ALARM_THRESH(4), .NUM_VECTORS(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  typedef struct {
    logic [3:0]  mm;
    logic [15:0] vec;
    logic [15:0] err;
  } exp_t;

  exp_t sb[$];
  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] exp_vec = '0;
  logic [15:0] exp_err = '0;
  // golden {E,F,G,H} for abc = 0..7, worked by hand from E=A&B F=A|C G=~C H=A&B&C
  logic [3:0] gold [8] = '{4'b0010, 4'b0100, 4'b0010, 4'b0100,
                           4'b0110, 4'b0100, 4'b1110, 4'b1101};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic stream_a(input logic [2:0] abc, input logic [3:0] resp, input logic [3:0] mm);
    exp_t e;
    @(negedge clk);
    ifa.in_valid = 1'b1;
    ifa.in_abc   = abc;
    ifa.in_resp  = resp;
    exp_vec = exp_vec + 16'd1;
    if (mm != 4'd0) exp_err = exp_err + 16'd1;
    e.mm = mm; e.vec = exp_vec; e.err = exp_err;
    sb.push_back(e);
  endtask

  task automatic idle_a();
    @(negedge clk);
    ifa.in_valid = 1'b0;
    ifa.in_abc   = '0;
    ifa.in_resp  = '0;
  endtask

  task automatic send_a(input logic [2:0] abc, input logic [3:0] resp, input logic [3:0] mm);
    stream_a(abc, resp, mm);
    idle_a();
    @(negedge clk);
  endtask

  task automatic start_a();
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    exp_vec = '0;
    exp_err = '0;
  endtask

  // Monitor: each time vec_cnt advances, a checked vector has been presented
  initial begin
    logic [15:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (ifa.vec_cnt != prev) && (ifa.vec_cnt != 16'd0)) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected: got vec_cnt=%0d required no new vector", ifa.vec_cnt);
        end else begin
          e = sb.pop_front();
          chk("sb_mismatch_vec", 32'(ifa.mismatch_vec), 32'(e.mm));
          chk("sb_vec_cnt", 32'(ifa.vec_cnt), 32'(e.vec));
          chk("sb_err_cnt", 32'(ifa.err_cnt), 32'(e.err));
        end
      end
      prev = ifa.vec_cnt;
    end
  end

  initial begin
    ifa.start = 1'b0; ifa.stop = 1'b0; ifa.in_valid = 1'b0; ifa.in_abc = '0; ifa.in_resp = '0;
    ifb.start = 1'b0; ifb.stop = 1'b0; ifb.in_valid = 1'b0; ifb.in_abc = '0; ifb.in_resp = '0;

    // reset state, then in_valid without start must be ignored
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(ifa.state), 0);
    chk("rst_vec_cnt", 32'(ifa.vec_cnt), 0);
    chk("rst_err_cnt", 32'(ifa.err_cnt), 0);
    chk("rst_alarm", 32'(ifa.alarm), 0);
    chk("rst_fail_mask", 32'(ifa.fail_mask), 0);
    chk("rst_first_fail_vld", 32'(ifa.first_fail_vld), 0);
    rst_n = 1'b1;
    @(negedge clk);
    ifa.in_valid = 1'b1; ifa.in_abc = 3'b100; ifa.in_resp = 4'b0000;
    repeat (3) @(negedge clk);
    ifa.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_state", 32'(ifa.state), 0);
    chk("idle_vec_cnt", 32'(ifa.vec_cnt), 0);

    // all eight vectors with golden responses, run ends at NUM_VECTORS
    start_a();
    for (int i = 0; i < 8; i++) stream_a(3'(i), gold[i], 4'b0000);
    idle_a();
    repeat (2) @(negedge clk);
    chk("run8_state", 32'(ifa.state), 3);
    chk("run8_vec_cnt", 32'(ifa.vec_cnt), 8);
    chk("run8_err_cnt", 32'(ifa.err_cnt), 0);
    chk("run8_fail_mask", 32'(ifa.fail_mask), 0);
    chk("run8_alarm", 32'(ifa.alarm), 0);

    // single failing vector and first-fail capture
    start_a();
    chk("start_state", 32'(ifa.state), 1);
    send_a(3'b100, 4'b0111, 4'b0001);
    chk("ff_mismatch_vec", 32'(ifa.mismatch_vec), 4'b0001);
    chk("ff_err_cnt", 32'(ifa.err_cnt), 1);
    chk("ff_abc", 32'(ifa.first_fail_abc), 3'b100);
    chk("ff_vld", 32'(ifa.first_fail_vld), 1);
    send_a(3'b111, 4'b0000, 4'b1101);
    chk("ff_abc_held", 32'(ifa.first_fail_abc), 3'b100);
    chk("ff_fail_mask", 32'(ifa.fail_mask), 4'b1101);

    // alarm at the 4th error, stop drains the in-flight vector, start clears
    start_a();
    for (int k = 0; k < 4; k++) begin
      send_a(3'b000, 4'b0000, 4'b0010);
      chk("thr_alarm", 32'(ifa.alarm), (k == 3) ? 1 : 0);
      chk("thr_state", 32'(ifa.state), (k == 3) ? 2 : 1);
    end
    chk("thr_fail_mask", 32'(ifa.fail_mask), 4'b0010);
    stream_a(3'b110, 4'b1110, 4'b0000);
    ifa.stop = 1'b1;
    @(negedge clk);
    ifa.stop = 1'b0; ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("stop_state", 32'(ifa.state), 3);
    chk("stop_alarm", 32'(ifa.alarm), 1);
    chk("stop_drain_vec_cnt", 32'(ifa.vec_cnt), 5);
    @(negedge clk);
    ifa.in_valid = 1'b1; ifa.in_abc = 3'b000; ifa.in_resp = 4'b0000;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("done_frozen_vec_cnt", 32'(ifa.vec_cnt), 5);
    start_a();
    chk("clr_state", 32'(ifa.state), 1);
    chk("clr_vec_cnt", 32'(ifa.vec_cnt), 0);
    chk("clr_err_cnt", 32'(ifa.err_cnt), 0);
    chk("clr_alarm", 32'(ifa.alarm), 0);
    chk("clr_mismatch_vec", 32'(ifa.mismatch_vec), 0);
    chk("clr_fail_mask", 32'(ifa.fail_mask), 0);
    chk("clr_first_fail_vld", 32'(ifa.first_fail_vld), 0);

    // asynchronous reset mid-run, then start beats stop
    send_a(3'b001, 4'b0000, 4'b0100);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(ifa.state), 0);
    chk("arst_vec_cnt", 32'(ifa.vec_cnt), 0);
    chk("arst_err_cnt", 32'(ifa.err_cnt), 0);
    chk("arst_fail_mask", 32'(ifa.fail_mask), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_vec = '0; exp_err = '0;
    @(negedge clk);
    ifa.start = 1'b1; ifa.stop = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0; ifa.stop = 1'b0;
    chk("start_beats_stop", 32'(ifa.state), 1);

    // saturation on 3-bit counters
    @(negedge clk);
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      ifb.in_valid = 1'b1; ifb.in_abc = 3'b000; ifb.in_resp = 4'b0000;
    end
    @(negedge clk);
    ifb.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("sat_err_cnt", 32'(ifb.err_cnt), 7);
    chk("sat_vec_cnt", 32'(ifb.vec_cnt), 7);
    chk("sat_alarm", 32'(ifb.alarm), 1);
    chk("sat_state", 32'(ifb.state), 2);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
